uart_frame_ctrl: RTL and testbench

- Controller for the 8N1 16× oversampled UART receiver.
- Generates the receiver's sample_tick (baud configuration) and consumes its data_ready/data_out byte stream.
- Sequences bytes into framed packets (SYNC, LEN, payload, CHK), buffers the payload, and hands complete frames to the consumer over a valid/ready handshake.
- Reports framing errors, timeouts and overruns.

---
 rtl/uart_frame_ctrl_if.sv | 24 ++
 rtl/uart_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream and frame-handoff signals between uart_frame_ctrl, the 16x UART receiver and the frame consumer.
// master = the controller side, slave = the receiver/consumer side.
interface uart_frame_ctrl_if;
  logic       sample_tick;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       frm_valid;
  logic       frm_ready;
  logic [4:0] frm_len;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       frm_err;
  logic [1:0] err_code;

  modport master (
    output sample_tick, frm_valid, frm_len, rd_data, frm_err, err_code,
    input  rx_ready, rx_data, frm_ready, rd_addr
  );

  modport slave (
    input  sample_tick, frm_valid, frm_len, rd_data, frm_err, err_code,
    output rx_ready, rx_data, frm_ready, rd_addr
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART frame controller: baud tick generator plus SYNC/LEN/payload[/CHK] framer with a held-frame buffer.
// Optional checksum byte and CHK state are built when UART_FRAME_CHK_EN is defined.
//
// state     | meaning
// S_HUNT    | waiting for SYNC_BYTE, other bytes dropped
// S_LEN     | expecting payload length 1..MAX_LEN
// S_PAYLOAD | storing payload bytes into the buffer
// S_CHK     | expecting XOR checksum (UART_FRAME_CHK_EN only)
// S_HOLD    | complete frame offered on frm_valid, buffer frozen
module uart_frame_ctrl #(
  parameter int          CLK_HZ        = 50000000,
  parameter int          BAUD          = 9600,
  parameter int          MAX_LEN       = 16,
  parameter logic [7:0]  SYNC_BYTE     = 8'hAA,
  parameter int          TIMEOUT_TICKS = 320
) (
  input  logic                  clk_50MHz,
  input  logic                  reset,
  uart_frame_ctrl_if.master     bus
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

`ifdef UART_FRAME_CHK_EN
  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;
`else
  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_HOLD} state_t;
`endif

  state_t                     state_q, state_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [TO_W-1:0]            to_q, to_d;
  logic [4:0]                 len_q, len_d;
  logic [4:0]                 idx_q, idx_d;
  logic [MAX_LEN-1:0][7:0]    mem_q, mem_d;
  logic                       frm_valid_q, frm_valid_d;
  logic [4:0]                 frm_len_q, frm_len_d;
  logic                       frm_err_q, frm_err_d;
  logic [1:0]                 err_code_q, err_code_d;
`ifdef UART_FRAME_CHK_EN
  logic [7:0]                 chk_q, chk_d;
`endif
  logic                       tick;
  logic                       timed;
  logic [7:0]                 rd_data;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

`ifdef UART_FRAME_CHK_EN
  assign timed = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
`else
  assign timed = (state_q == S_LEN) || (state_q == S_PAYLOAD);
`endif

  always_comb begin
    state_d     = state_q;
    to_d        = to_q;
    len_d       = len_q;
    idx_d       = idx_q;
    mem_d       = mem_q;
    frm_valid_d = frm_valid_q;
    frm_len_d   = frm_len_q;
    frm_err_d   = 1'b0;
    err_code_d  = err_code_q;
`ifdef UART_FRAME_CHK_EN
    chk_d       = chk_q;
`endif
    case (state_q)
      S_HUNT: begin
        if (bus.rx_ready && bus.rx_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (bus.rx_ready) begin
          if (bus.rx_data != 8'd0 && bus.rx_data <= MAX_LEN_B) begin
            len_d   = bus.rx_data[4:0];
            idx_d   = '0;
`ifdef UART_FRAME_CHK_EN
            chk_d   = bus.rx_data;
`endif
            state_d = S_PAYLOAD;
          end else begin
            frm_err_d  = 1'b1;
            err_code_d = 2'd1;
            state_d    = S_HUNT;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_ready) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 5'(i)) mem_d[i] = bus.rx_data;
          end
          idx_d = idx_q + 5'd1;
`ifdef UART_FRAME_CHK_EN
          chk_d = chk_q ^ bus.rx_data;
          if (idx_q == len_q - 5'd1) state_d = S_CHK;
`else
          if (idx_q == len_q - 5'd1) begin
            state_d     = S_HOLD;
            frm_valid_d = 1'b1;
            frm_len_d   = len_q;
          end
`endif
        end
      end
`ifdef UART_FRAME_CHK_EN
      S_CHK: begin
        if (bus.rx_ready) begin
          if (bus.rx_data == chk_q) begin
            state_d     = S_HOLD;
            frm_valid_d = 1'b1;
            frm_len_d   = len_q;
          end else begin
            frm_err_d  = 1'b1;
            err_code_d = 2'd2;
            state_d    = S_HUNT;
          end
        end
      end
`endif
      S_HOLD: begin
        // A release in the same cycle as a byte frees the slot, so the byte is hunted, not overrun.
        if (bus.frm_ready) begin
          frm_valid_d = 1'b0;
          state_d     = (bus.rx_ready && bus.rx_data == SYNC_BYTE) ? S_LEN : S_HUNT;
        end else if (bus.rx_ready) begin
          frm_err_d  = 1'b1;
          err_code_d = 2'd3;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // A byte arriving on the limiting tick wins over the timeout.
    if (!timed || bus.rx_ready) begin
      to_d = '0;
    end else if (tick) begin
      if (to_q == TO_LAST) begin
        to_d       = '0;
        frm_err_d  = 1'b1;
        err_code_d = 2'd0;
        state_d    = S_HUNT;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q     <= S_HUNT;
      div_q       <= '0;
      to_q        <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      mem_q       <= '0;
      frm_valid_q <= 1'b0;
      frm_len_q   <= '0;
      frm_err_q   <= 1'b0;
      err_code_q  <= '0;
`ifdef UART_FRAME_CHK_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      to_q        <= to_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      mem_q       <= mem_d;
      frm_valid_q <= frm_valid_d;
      frm_len_q   <= frm_len_d;
      frm_err_q   <= frm_err_d;
      err_code_q  <= err_code_d;
`ifdef UART_FRAME_CHK_EN
      chk_q       <= chk_d;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (bus.rd_addr == 5'(i)) rd_data = mem_q[i];
    end
  end

  assign bus.sample_tick = tick;
  assign bus.frm_valid   = frm_valid_q;
  assign bus.frm_len     = frm_len_q;
  assign bus.rd_data     = rd_data;
  assign bus.frm_err     = frm_err_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: expected frames/errors queued at stimulus time, checked as the DUT reports them.
// Works with or without UART_FRAME_CHK_EN.
module tb_uart_frame_ctrl;

  localparam logic [7:0] SYNC = 8'hAA;

  typedef struct packed {
    logic [4:0]       len;
    logic [15:0][7:0] d;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic valid_prev = 1'b0;

  frame_t     exp_frames[$];
  logic [1:0] exp_errs[$];
  logic [7:0] pl[$];

  uart_frame_ctrl_if bus_if();

  uart_frame_ctrl #(
    .CLK_HZ(1600), .BAUD(10), .MAX_LEN(16), .SYNC_BYTE(8'hAA), .TIMEOUT_TICKS(20)
  ) dut (
    .clk_50MHz(clk),
    .reset(reset),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Error scoreboard: every frm_err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      valid_prev <= 1'b0;
    end else begin
      if (bus_if.frm_err) begin
        if (exp_errs.size() > 0) check_val("err_code", 32'(bus_if.err_code), 32'(exp_errs.pop_front()));
        else check_val("unexpected_err", 32'(bus_if.frm_err), 32'd0);
      end
      if (bus_if.frm_valid && !valid_prev && exp_frames.size() == 0)
        check_val("unexpected_valid", 32'(bus_if.frm_valid), 32'd0);
      valid_prev <= bus_if.frm_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    bus_if.rx_ready = 1'b1;
    bus_if.rx_data  = b;
    @(negedge clk);
    bus_if.rx_ready = 1'b0;
    bus_if.rx_data  = 8'h00;
  endtask

  task automatic send_frame();
    frame_t     f;
    logic [7:0] c;
    int         n;
    n = pl.size();
    f = '0;
    f.len = 5'(n);
    c = 8'(n);
    for (int i = 0; i < n; i++) begin
      f.d[i] = pl[i];
      c = c ^ pl[i];
    end
    send_byte(SYNC);
    send_byte(8'(n));
    for (int i = 0; i < n - 1; i++) send_byte(pl[i]);
`ifdef UART_FRAME_CHK_EN
    send_byte(pl[n-1]);
    exp_frames.push_back(f);
    send_byte(c);
`else
    exp_frames.push_back(f);
    send_byte(pl[n-1]);
`endif
    check_val("valid_latency", 32'(bus_if.frm_valid), 32'd1);
  endtask

  task automatic verify_frame();
    frame_t f;
    if (exp_frames.size() == 0) return;
    f = exp_frames[0];
    check_val("frm_valid", 32'(bus_if.frm_valid), 32'd1);
    check_val("frm_len", 32'(bus_if.frm_len), 32'(f.len));
    for (int i = 0; i < int'(f.len); i++) begin
      bus_if.rd_addr = 5'(i);
      #1;
      check_val($sformatf("rd_data[%0d]", i), 32'(bus_if.rd_data), 32'(f.d[i]));
    end
    bus_if.rd_addr = 5'd16;
    #1;
    check_val("rd_data_oob16", 32'(bus_if.rd_data), 32'd0);
    bus_if.rd_addr = 5'd31;
    #1;
    check_val("rd_data_oob31", 32'(bus_if.rd_data), 32'd0);
    bus_if.rd_addr = 5'd0;
  endtask

  task automatic release_frame();
    @(negedge clk);
    bus_if.frm_ready = 1'b1;
    @(negedge clk);
    bus_if.frm_ready = 1'b0;
    check_val("valid_release", 32'(bus_if.frm_valid), 32'd0);
    if (exp_frames.size() > 0) void'(exp_frames.pop_front());
  endtask

  task automatic wait_errs();
    int k;
    k = 0;
    while (exp_errs.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val("err_drained", 32'(exp_errs.size()), 32'd0);
    exp_errs.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(bus_if.frm_valid), 32'd0);
    check_val({tag, "_len"}, 32'(bus_if.frm_len), 32'd0);
    check_val({tag, "_err"}, 32'(bus_if.frm_err), 32'd0);
    check_val({tag, "_code"}, 32'(bus_if.err_code), 32'd0);
    check_val({tag, "_tick"}, 32'(bus_if.sample_tick), 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus_if.rd_addr = 5'(a);
      #1;
      check_val($sformatf("%s_mem[%0d]", tag, a), 32'(bus_if.rd_data), 32'd0);
    end
    bus_if.rd_addr = 5'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int k;
    frame_t f;
    bus_if.rx_ready  = 1'b0;
    bus_if.rx_data   = 8'h00;
    bus_if.frm_ready = 1'b0;
    bus_if.rd_addr   = 5'd0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    // Tick generator: DIV=10, tick high while the counter sits at 9.
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      check_val($sformatf("tick_c%0d", c), 32'(bus_if.sample_tick), 32'((c % 10) == 9));
    end

    // Stray byte in HUNT is dropped, then a good 3-byte frame.
    send_byte(8'h55);
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame();
    verify_frame();
    release_frame();

`ifdef UART_FRAME_CHK_EN
    exp_errs.push_back(2'd2);
    send_byte(SYNC); send_byte(8'h02); send_byte(8'h05); send_byte(8'h06);
    send_byte(8'hFF);
    check_val("chk_err_pulse", 32'(bus_if.frm_err), 32'd1);
    wait_errs();
    check_val("chk_no_valid", 32'(bus_if.frm_valid), 32'd0);
`endif

    exp_errs.push_back(2'd1);
    send_byte(SYNC); send_byte(8'h00);
    check_val("len0_err_pulse", 32'(bus_if.frm_err), 32'd1);
    wait_errs();
    exp_errs.push_back(2'd1);
    send_byte(SYNC); send_byte(8'h20);
    check_val("len32_err_pulse", 32'(bus_if.frm_err), 32'd1);
    wait_errs();
    exp_errs.push_back(2'd1);
    send_byte(SYNC); send_byte(8'h11);
    check_val("len17_err_pulse", 32'(bus_if.frm_err), 32'd1);
    wait_errs();

    // Full-depth frame.
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(i * 7 + 1));
    send_frame();
    verify_frame();
    release_frame();

    // Timeout: a byte one tick short of the limit survives, then silence times out after 20 ticks.
    send_byte(SYNC); send_byte(8'h04); send_byte(8'h01);
    ticks = 0;
    k = 0;
    while (ticks < 19 && k < 400) begin
      if (bus_if.sample_tick) ticks++;
      if (ticks < 19) begin
        @(negedge clk);
        k++;
      end
    end
    send_byte(8'h02);
    exp_errs.push_back(2'd0);
    ticks = 0;
    k = 0;
    while (!bus_if.frm_err && k < 400) begin
      if (bus_if.sample_tick) ticks++;
      @(negedge clk);
      k++;
    end
    check_val("timeout_pulse", 32'(bus_if.frm_err), 32'd1);
    check_val("timeout_ticks", 32'(ticks), 32'd20);
    wait_errs();
    pl = '{8'h7E};
    send_frame();
    verify_frame();
    release_frame();

    // Overrun while holding, then release coinciding with a SYNC byte.
    pl = '{8'h5A, 8'hA5};
    send_frame();
    verify_frame();
    exp_errs.push_back(2'd3);
    send_byte(8'h55);
    check_val("overrun_pulse", 32'(bus_if.frm_err), 32'd1);
    wait_errs();
    verify_frame();
    @(negedge clk);
    bus_if.frm_ready = 1'b1;
    bus_if.rx_ready  = 1'b1;
    bus_if.rx_data   = SYNC;
    @(negedge clk);
    bus_if.frm_ready = 1'b0;
    bus_if.rx_ready  = 1'b0;
    bus_if.rx_data   = 8'h00;
    check_val("simul_valid", 32'(bus_if.frm_valid), 32'd0);
    check_val("simul_no_err", 32'(bus_if.frm_err), 32'd0);
    void'(exp_frames.pop_front());
    f = '0;
    f.len = 5'd1;
    f.d[0] = 8'h09;
    send_byte(8'h01);
`ifdef UART_FRAME_CHK_EN
    send_byte(8'h09);
    exp_frames.push_back(f);
    send_byte(8'h08);
`else
    exp_frames.push_back(f);
    send_byte(8'h09);
`endif
    check_val("simul_frame_latency", 32'(bus_if.frm_valid), 32'd1);
    verify_frame();
    release_frame();

    // Reset mid-frame clears everything, then a fresh frame.
    send_byte(SYNC); send_byte(8'h03); send_byte(8'h11);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    pl = '{8'hC3, 8'h3C, 8'h01, 8'h80};
    send_frame();
    verify_frame();
    release_frame();

    repeat (5) @(negedge clk);
    check_val("sb_errs_left", 32'(exp_errs.size()), 32'd0);
    check_val("sb_frames_left", 32'(exp_frames.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
